// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: sequencer state
// encodings, pipeline-register stage indices and the hardwired zero register.
package pipe_ctrl_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MEM_WAIT  = 2'd1,
    ST_IRQ_DRAIN = 2'd2
  } pipe_state_e;

  // Pipeline-register indices used for the per-stage enable/bubble vectors
  localparam int unsigned STG_IFID   = 0;
  localparam int unsigned STG_IDEX   = 1;
  localparam int unsigned STG_EXMEM  = 2;
  localparam int unsigned STG_MEMWB  = 3;
  localparam int unsigned NUM_STAGES = 4;

  // Register $zero never carries a real dependency
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : pipe_ctrl_pkg

// File: rtl/hazard_detect_comb.sv
// Pure combinational load-use detector: flags when the load currently in EX
// writes a register that the instruction in ID is about to read.
module hazard_detect_comb
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  output logic       load_use
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (ex_rt == id_rs);
  // rt only matters when the ID instruction actually reads it as a source
  assign rt_match = id_uses_rt && (ex_rt == id_rt);
  // A load into $zero produces no value that anyone can depend on
  assign load_use = ex_mem_read && (ex_rt != REG_ZERO) && (rs_match || rt_match);

endmodule : hazard_detect_comb

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencer for the PC and the IF/ID, ID/EX, EX/MEM, MEM/WB pipeline
// registers: load-use stalls, branch/jump squashes, data-memory wait states
// and interrupt entry (drain older instructions, then fetch the vector).
// Optional build macro PIPE_CTRL_STATS_EN adds Stall_Count, Flush_Count and
// Mem_Wait_Count event counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT  = 256,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  IFID_Rs,
  input  logic [4:0]  IFID_Rt,
  input  logic        ID_UsesRt,
  input  logic        ID_Jump,
  input  logic        IDEX_MemRead,
  input  logic [4:0]  IDEX_Rt,
  input  logic        EX_BranchTaken,
  input  logic        Mem_Busy,
  input  logic        Irq,
  input  logic        Eret,
  output logic        PC_Write,
  output logic        Irq_Vec_Sel,
  output logic        IFID_Write,
  output logic        IFID_Flush,
  output logic        IDEX_Write,
  output logic        IDEX_Flush,
  output logic        EXMEM_Write,
  output logic        EXMEM_Flush,
  output logic        MEMWB_Write,
  output logic        MEMWB_Flush,
  output logic        Irq_Take,
  output logic        Kernel,
  output logic        Mem_Timeout
`ifdef PIPE_CTRL_STATS_EN
  ,
  output logic [31:0] Stall_Count,
  output logic [31:0] Flush_Count,
  output logic [31:0] Mem_Wait_Count
`endif
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [3:0]        DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  pipe_state_e       state_reg, state_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic [3:0]        drain_cnt_reg, drain_cnt_next;
  logic              kernel_reg, kernel_next;
  logic              timeout_reg, timeout_next;

  logic              load_use;
  logic              in_drain;
  logic              run_eval;
  logic              r_branch, r_lu, r_jump, r_irq;
  logic              drain_last;
  logic [WAIT_W-1:0] wait_inc;

  // Raw per-stage enables/bubbles before reset gating and exclusivity
  logic [NUM_STAGES-1:0] wr_raw, fl_raw;
  logic [NUM_STAGES-1:0] wr_out, fl_out;
  logic                  pc_raw, vec_raw, take_raw;

  hazard_detect_comb u_hazard (
    .id_rs       (IFID_Rs),
    .id_rt       (IFID_Rt),
    .id_uses_rt  (ID_UsesRt),
    .ex_mem_read (IDEX_MemRead),
    .ex_rt       (IDEX_Rt),
    .load_use    (load_use)
  );

  // Rule decode shared by next-state and output logic. MEM_WAIT with the
  // memory ready is evaluated exactly like RUN, so only "busy" and "drain"
  // need special handling; everything else falls into the priority chain.
  assign in_drain   = (state_reg == ST_IRQ_DRAIN);
  assign run_eval   = !in_drain && !Mem_Busy;
  assign r_branch   = run_eval && EX_BranchTaken;
  assign r_lu       = run_eval && !EX_BranchTaken && load_use;
  assign r_jump     = run_eval && !EX_BranchTaken && !load_use && ID_Jump;
  assign r_irq      = run_eval && !EX_BranchTaken && !load_use && !ID_Jump &&
                      Irq && !kernel_reg && !Eret;
  assign drain_last = in_drain && !Mem_Busy && (drain_cnt_reg == 4'd0);
  assign wait_inc   = (wait_cnt_reg == WAIT_MAX) ? WAIT_MAX : wait_cnt_reg + 1'b1;

  // State register: sequencer state, wait/drain counters, Kernel and timeout flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_RUN;
      wait_cnt_reg  <= '0;
      drain_cnt_reg <= 4'd0;
      kernel_reg    <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wait_cnt_reg  <= wait_cnt_next;
      drain_cnt_reg <= drain_cnt_next;
      kernel_reg    <= kernel_next;
      timeout_reg   <= timeout_next;
    end
  end

  // Next-state logic: memory freeze dominates, then drain progress, then IRQ entry
  always_comb begin
    state_next     = ST_RUN;
    wait_cnt_next  = '0;
    drain_cnt_next = drain_cnt_reg;
    kernel_next    = kernel_reg;
    timeout_next   = timeout_reg;

    if (Mem_Busy) begin
      // Freeze: drain stays put with its counter held
      wait_cnt_next = wait_inc;
      if (wait_inc == WAIT_MAX)
        timeout_next = 1'b1;
      state_next = in_drain ? ST_IRQ_DRAIN : ST_MEM_WAIT;
    end else begin
      case (state_reg)
        ST_RUN, ST_MEM_WAIT: begin
          if (r_irq) begin
            state_next     = ST_IRQ_DRAIN;
            drain_cnt_next = DRAIN_INIT;
          end else begin
            state_next = ST_RUN;
          end
        end
        ST_IRQ_DRAIN: begin
          if (drain_last) begin
            state_next = ST_RUN;
          end else begin
            state_next     = ST_IRQ_DRAIN;
            drain_cnt_next = drain_cnt_reg - 4'd1;
          end
        end
        default: state_next = ST_RUN;
      endcase
    end

    // Handler entry wins over a coincident return pulse
    if (drain_last)
      kernel_next = 1'b1;
    else if (Eret)
      kernel_next = 1'b0;
  end

  // Output logic: per-stage enables/bubbles from state and current inputs
  always_comb begin
    pc_raw   = 1'b1;
    vec_raw  = 1'b0;
    take_raw = 1'b0;
    wr_raw   = '1;
    fl_raw   = '0;

    if (Mem_Busy) begin
      pc_raw            = 1'b0;
      wr_raw[STG_IFID]  = 1'b0;
      wr_raw[STG_IDEX]  = 1'b0;
      wr_raw[STG_EXMEM] = 1'b0;
      fl_raw[STG_MEMWB] = 1'b1;
    end else if (in_drain) begin
      // Older instructions advance; no new ones enter until the vector fetch
      pc_raw           = drain_last;
      vec_raw          = drain_last;
      wr_raw[STG_IFID] = 1'b0;
      fl_raw[STG_IDEX] = 1'b1;
    end else if (r_branch) begin
      fl_raw[STG_IFID] = 1'b1;
      fl_raw[STG_IDEX] = 1'b1;
    end else if (r_lu) begin
      pc_raw           = 1'b0;
      wr_raw[STG_IFID] = 1'b0;
      fl_raw[STG_IDEX] = 1'b1;
    end else if (r_jump) begin
      fl_raw[STG_IFID] = 1'b1;
    end else if (r_irq) begin
      take_raw         = 1'b1;
      pc_raw           = 1'b0;
      fl_raw[STG_IFID] = 1'b1;
      fl_raw[STG_IDEX] = 1'b1;
    end
  end

  // A bubbled stage is never also enabled; everything reads 0 while in reset
  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      assign wr_out[gi] = !reset && wr_raw[gi] && !fl_raw[gi];
      assign fl_out[gi] = !reset && fl_raw[gi];
    end
  endgenerate

  assign PC_Write    = !reset && pc_raw;
  assign Irq_Vec_Sel = !reset && vec_raw;
  assign Irq_Take    = !reset && take_raw;
  assign IFID_Write  = wr_out[STG_IFID];
  assign IFID_Flush  = fl_out[STG_IFID];
  assign IDEX_Write  = wr_out[STG_IDEX];
  assign IDEX_Flush  = fl_out[STG_IDEX];
  assign EXMEM_Write = wr_out[STG_EXMEM];
  assign EXMEM_Flush = fl_out[STG_EXMEM];
  assign MEMWB_Write = wr_out[STG_MEMWB];
  assign MEMWB_Flush = fl_out[STG_MEMWB];
  assign Kernel      = kernel_reg;
  assign Mem_Timeout = timeout_reg;

`ifdef PIPE_CTRL_STATS_EN
  logic [31:0] stall_cnt_reg, flush_cnt_reg, mem_wait_cnt_reg;

  // Event counters: load-use stalls, squash cycles and memory wait cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_reg    <= 32'd0;
      flush_cnt_reg    <= 32'd0;
      mem_wait_cnt_reg <= 32'd0;
    end else begin
      if (r_lu)
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      if (r_branch || r_jump || r_irq)
        flush_cnt_reg <= flush_cnt_reg + 32'd1;
      if (Mem_Busy)
        mem_wait_cnt_reg <= mem_wait_cnt_reg + 32'd1;
    end
  end

  assign Stall_Count    = stall_cnt_reg;
  assign Flush_Count    = flush_cnt_reg;
  assign Mem_Wait_Count = mem_wait_cnt_reg;
`endif

endmodule : pipeline_hazard_ctrl

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: table of single-cycle hazard vectors
// followed by hand-written multi-cycle sequences (memory freeze, timeout,
// interrupt entry/return, reset during drain). Expected outputs are queued
// when stimulus is driven and compared when sampled on the falling edge.
module tb_pipeline_hazard_ctrl;

  // Output vector bit order (MSB first):
  // PC_Write Irq_Vec_Sel IFID_W IFID_F IDEX_W IDEX_F EXMEM_W EXMEM_F MEMWB_W MEMWB_F Irq_Take Kernel Mem_Timeout
  localparam logic [12:0] E_ZERO   = 13'b0_0_0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [12:0] E_DEF    = 13'b1_0_1_0_1_0_1_0_1_0_0_0_0;
  localparam logic [12:0] E_BRANCH = 13'b1_0_0_1_0_1_1_0_1_0_0_0_0;
  localparam logic [12:0] E_LU     = 13'b0_0_0_0_0_1_1_0_1_0_0_0_0;
  localparam logic [12:0] E_JUMP   = 13'b1_0_0_1_1_0_1_0_1_0_0_0_0;
  localparam logic [12:0] E_FREEZE = 13'b0_0_0_0_0_0_0_0_0_1_0_0_0;
  localparam logic [12:0] E_TAKE   = 13'b0_0_0_1_0_1_1_0_1_0_1_0_0;
  localparam logic [12:0] E_DRAIN  = 13'b0_0_0_0_0_1_1_0_1_0_0_0_0;
  localparam logic [12:0] E_DLAST  = 13'b1_1_0_0_0_1_1_0_1_0_0_0_0;
  localparam logic [12:0] B_KERNEL = 13'b0_0_0_0_0_0_0_0_0_0_0_1_0;
  localparam logic [12:0] B_TMO    = 13'b0_0_0_0_0_0_0_0_0_0_0_0_1;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        uses_rt;
    logic        jump;
    logic        memread;
    logic [4:0]  ex_rt;
    logic        br;
    logic        busy;
    logic        irq;
    logic        eret;
    logic [12:0] exp;
  } vec_t;

  logic        clk, reset;
  logic [4:0]  IFID_Rs, IFID_Rt, IDEX_Rt;
  logic        ID_UsesRt, ID_Jump, IDEX_MemRead, EX_BranchTaken, Mem_Busy, Irq, Eret;
  logic        PC_Write, Irq_Vec_Sel, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush;
  logic        EXMEM_Write, EXMEM_Flush, MEMWB_Write, MEMWB_Flush, Irq_Take, Kernel, Mem_Timeout;

  int          passed;
  int          total;
  logic [12:0] exp_q[$];
  string       nm_q[$];
  vec_t        tbl[12];
  string       tbl_nm[12];

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(8), .DRAIN_CYCLES(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .IFID_Rs        (IFID_Rs),
    .IFID_Rt        (IFID_Rt),
    .ID_UsesRt      (ID_UsesRt),
    .ID_Jump        (ID_Jump),
    .IDEX_MemRead   (IDEX_MemRead),
    .IDEX_Rt        (IDEX_Rt),
    .EX_BranchTaken (EX_BranchTaken),
    .Mem_Busy       (Mem_Busy),
    .Irq            (Irq),
    .Eret           (Eret),
    .PC_Write       (PC_Write),
    .Irq_Vec_Sel    (Irq_Vec_Sel),
    .IFID_Write     (IFID_Write),
    .IFID_Flush     (IFID_Flush),
    .IDEX_Write     (IDEX_Write),
    .IDEX_Flush     (IDEX_Flush),
    .EXMEM_Write    (EXMEM_Write),
    .EXMEM_Flush    (EXMEM_Flush),
    .MEMWB_Write    (MEMWB_Write),
    .MEMWB_Flush    (MEMWB_Flush),
    .Irq_Take       (Irq_Take),
    .Kernel         (Kernel),
    .Mem_Timeout    (Mem_Timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                              input logic jump, input logic memread, input logic [4:0] ex_rt,
                              input logic br, input logic busy, input logic irq, input logic eret,
                              input logic [12:0] exp);
    vec_t v;
    v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.jump = jump; v.memread = memread;
    v.ex_rt = ex_rt; v.br = br; v.busy = busy; v.irq = irq; v.eret = eret; v.exp = exp;
    return v;
  endfunction

  // Drive one cycle just after the rising edge, queue its expectation,
  // then sample and compare on the falling edge.
  task automatic apply(input vec_t v, input string nm);
    logic [12:0] act;
    logic [12:0] e;
    string       n;
    IFID_Rs = v.rs; IFID_Rt = v.rt; ID_UsesRt = v.uses_rt; ID_Jump = v.jump;
    IDEX_MemRead = v.memread; IDEX_Rt = v.ex_rt; EX_BranchTaken = v.br;
    Mem_Busy = v.busy; Irq = v.irq; Eret = v.eret;
    exp_q.push_back(v.exp);
    nm_q.push_back(nm);
    @(negedge clk);
    act = {PC_Write, Irq_Vec_Sel, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush,
           EXMEM_Write, EXMEM_Flush, MEMWB_Write, MEMWB_Flush, Irq_Take, Kernel, Mem_Timeout};
    e = exp_q.pop_front();
    n = nm_q.pop_front();
    total++;
    if (act === e) begin
      passed++;
      $display("ok   %-16s outs=%b", n, act);
    end else begin
      $display("FAIL %-16s got=%b want=%b", n, act, e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset = 1'b1;
    IFID_Rs = '0; IFID_Rt = '0; ID_UsesRt = 1'b0; ID_Jump = 1'b0; IDEX_MemRead = 1'b0;
    IDEX_Rt = '0; EX_BranchTaken = 1'b0; Mem_Busy = 1'b0; Irq = 1'b0; Eret = 1'b0;

    //               rs    rt    urt jmp mrd exrt  br  bsy irq ert expected
    tbl[0]  = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, E_DEF);    tbl_nm[0]  = "idle";
    tbl[1]  = mk(5'd8, 5'd10,1, 0, 1, 5'd8, 0, 0, 0, 0, E_LU);     tbl_nm[1]  = "lu_rs";
    tbl[2]  = mk(5'd9, 5'd8, 1, 0, 1, 5'd8, 0, 0, 0, 0, E_LU);     tbl_nm[2]  = "lu_rt";
    tbl[3]  = mk(5'd9, 5'd8, 0, 0, 1, 5'd8, 0, 0, 0, 0, E_DEF);    tbl_nm[3]  = "rt_not_used";
    tbl[4]  = mk(5'd0, 5'd0, 1, 0, 1, 5'd0, 0, 0, 0, 0, E_DEF);    tbl_nm[4]  = "load_to_zero";
    tbl[5]  = mk(5'd8, 5'd8, 1, 0, 0, 5'd8, 0, 0, 0, 0, E_DEF);    tbl_nm[5]  = "no_memread";
    tbl[6]  = mk(5'd8, 5'd10,1, 0, 1, 5'd8, 1, 0, 0, 0, E_BRANCH); tbl_nm[6]  = "branch_over_lu";
    tbl[7]  = mk(5'd1, 5'd2, 1, 1, 0, 5'd0, 0, 0, 0, 0, E_JUMP);   tbl_nm[7]  = "jump";
    tbl[8]  = mk(5'd8, 5'd2, 0, 1, 1, 5'd8, 0, 0, 0, 0, E_LU);     tbl_nm[8]  = "lu_over_jump";
    tbl[9]  = mk(5'd1, 5'd2, 1, 1, 0, 5'd0, 1, 0, 0, 0, E_BRANCH); tbl_nm[9]  = "branch_over_jump";
    tbl[10] = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 1, E_DEF);    tbl_nm[10] = "irq_with_eret";
    tbl[11] = mk(5'd31,5'd3, 0, 0, 1, 5'd31,0, 0, 0, 0, E_LU);     tbl_nm[11] = "lu_r31";

    // Reset state: every output low while reset is held
    @(posedge clk);
    #1;
    apply(mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, E_ZERO), "in_reset");
    reset = 1'b0;

    for (int i = 0; i < 12; i++)
      apply(tbl[i], tbl_nm[i]);

    // Memory freeze for 4 cycles, resume on the 5th, no timeout
    for (int i = 0; i < 4; i++)
      apply(mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0, E_FREEZE), "busy4_freeze");
    apply(mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, E_DEF), "busy4_resume");

    // Busy for 10 cycles: timeout visible from cycle 8, sticky afterwards
    for (int i = 1; i <= 10; i++)
      apply(mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0,
               (i >= 8) ? (E_FREEZE | B_TMO) : E_FREEZE), "busy10");
    apply(mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, E_DEF | B_TMO), "timeout_sticky");

    // Reset clears the sticky flag
    reset = 1'b1;
    apply(mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, E_ZERO), "reset2");
    reset = 1'b0;
    apply(mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, E_DEF), "after_reset2");

    // Interrupt entry: take, three drain cycles, vector on the last
    apply(mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 0, E_TAKE), "irq_take");
    apply(mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 0, E_DRAIN), "drain1");
    apply(mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 0, E_DRAIN), "drain2");
    apply(mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 0, E_DLAST), "drain3_vec");
    apply(mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 0, E_DEF | B_KERNEL), "irq_masked");
    apply(mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 1, E_DEF | B_KERNEL), "eret_pulse");
    apply(mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 0, E_TAKE), "irq_take2");
    // Mem_Busy inside drain freezes without consuming a drain cycle
    apply(mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, 0, E_FREEZE), "drain_busy");
    apply(mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 0, E_DRAIN), "drain2_1");
    apply(mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 0, E_DRAIN), "drain2_2");
    // Reset mid-drain: outputs drop at once, clean RUN afterwards
    reset = 1'b1;
    apply(mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 0, E_ZERO), "reset_in_drain");
    reset = 1'b0;
    apply(mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, E_DEF), "after_drain_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_pipeline_hazard_ctrl
